fetch_stall_ctrl: RTL and testbench
===================================

FETCH_STALL_CTRL -- requirements
Module: fetch_stall_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning the width of the redirect address.
REQ-002 SHALL have port Clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-003 SHALL have port Rst, input, 1 bit, meaning the asynchronous, active-low reset.
REQ-004 SHALL have port Imiss, input, 1 bit, meaning the fetch instruction-cache miss is pending this cycle.
REQ-005 SHALL have port DStall, input, 1 bit, meaning the data-memory stall; the whole front end freezes.
REQ-006 SHALL have port LoadUse, input, 1 bit, meaning a decode load-use hazard that requires a one-cycle bubble.
REQ-007 SHALL have port FlushPipeandPC, input, 1 bit, meaning a branch-unit redirect request; it is held by the branch unit while DStall=1.
REQ-008 SHALL have port JmpAddr, input, ADDR_W bits, meaning the redirect target, valid with FlushPipeandPC.
REQ-009 SHALL have port PCStall, output, 1 bit, meaning the PC hold.
REQ-010 SHALL have port IF_ID_Stall, output, 1 bit, meaning the IF/ID register hold.
REQ-011 SHALL have port IF_ID_Flush, output, 1 bit, meaning the IF/ID register clear (bubble).
REQ-012 SHALL have port ID_EX_Flush, output, 1 bit, meaning the ID/EX register clear.
REQ-013 SHALL have port RedirectReplay, output, 1 bit, meaning a one-cycle pulse that makes fetch load ReplayAddr into the PC.
REQ-014 SHALL have port ReplayAddr, output, ADDR_W bits, meaning the stored redirect target.
REQ-015 SHALL have port StallCycles, output, 32 bits, meaning the front-end stall count (only with FETCH_STALL_CNT_EN).

Function
REQ-016 SHALL implement a 3-state FSM {RUN, IMISS, REPLAY}; outputs are combinational from state and inputs, with zero latency.
REQ-017 SHALL, in RUN, apply these priorities in order:
- DStall: PCStall=1, IF_ID_Stall=1, all flushes 0; state holds.
- FlushPipeandPC: IF_ID_Flush=1, ID_EX_Flush=1, PCStall=0.
- Imiss: PCStall=1, IF_ID_Flush=1; next state IMISS.
- LoadUse: PCStall=1, IF_ID_Stall=1, ID_EX_Flush=1.
- Otherwise: all outputs 0.
REQ-018 SHALL, in IMISS with Imiss=1, assert PCStall=1 and IF_ID_Flush=1 every cycle.
REQ-019 SHALL, in IMISS with FlushPipeandPC=1 and DStall=0, capture JmpAddr into ReplayAddr, set the pending flag, and assert ID_EX_Flush=1; a later redirect in the same miss overwrites the captured address (the last one wins).
REQ-020 SHALL, in IMISS with Imiss=0, go to REPLAY if the pending flag is set, otherwise go to RUN with the RUN rules applied that same cycle.
REQ-021 SHALL, in REPLAY, assert RedirectReplay=1, IF_ID_Flush=1 and PCStall=0 for exactly one cycle, clear the pending flag, and go to RUN.
REQ-022 SHALL, when DStall=1 in IMISS or REPLAY, additionally assert IF_ID_Stall=1 and suppress all state transitions and captures; REPLAY is extended until DStall=0.
REQ-023 SHALL never assert IF_ID_Stall=1 and IF_ID_Flush=1 in the same cycle; where both would apply, the stall wins.
REQ-024 SHALL hold ReplayAddr stable except on capture.

Reset
REQ-025 SHALL, on Rst=0, immediately set state=RUN, pending=0, ReplayAddr=0 and StallCycles=0; all outputs are then 0 except as derived from the inputs in RUN.
REQ-026 SHALL, when reset occurs mid-miss, discard the pending redirect, with no RedirectReplay after release.

Configuration
REQ-027 SHALL, with FETCH_STALL_CNT_EN defined, increment a 32-bit StallCycles every cycle PCStall=1, saturating at 0xFFFFFFFF.
REQ-028 SHALL, without FETCH_STALL_CNT_EN, tie StallCycles to 0 and include no counter flops.

Structure
REQ-029 SHALL take its FSM state encoding (2 bits) from the shared pipeline definitions package.
REQ-030 SHALL put the optional saturating counter in sub-module stall_counter.

Verification
REQ-031 SHALL cover this scenario: Imiss high for 5 cycles from RUN → PCStall=1 and IF_ID_Flush=1 for 5 cycles, return to RUN, RedirectReplay never asserted.
REQ-032 SHALL cover this scenario: a miss with FlushPipeandPC/JmpAddr=0x0000_0040 on miss cycle 2, then 0x0000_0080 on cycle 3 → after Imiss falls, a single RedirectReplay pulse with ReplayAddr=0x0000_0080.
REQ-033 SHALL cover this scenario: LoadUse=1 with FlushPipeandPC=1 in RUN → IF_ID_Flush=1, ID_EX_Flush=1, PCStall=0, IF_ID_Stall=0.
REQ-034 SHALL cover this scenario: DStall=1 for 3 cycles while in REPLAY → RedirectReplay=1 and IF_ID_Stall=1 throughout, IF_ID_Flush=0, exactly one further replay cycle after DStall drops.
REQ-035 SHALL cover this scenario: Rst pulsed low while in IMISS with a pending redirect → state RUN, ReplayAddr=0, no replay afterwards.
REQ-036 SHALL cover this scenario: with FETCH_STALL_CNT_EN defined and the counter preloaded to 0xFFFFFFFE, 4 stall cycles → StallCycles=0xFFFFFFFF.

Source files
------------

// File: rtl/fetch_stall_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stall_ctrl_pkg
// Description : Shared front-end pipeline definitions: fetch-control FSM
//               state encoding, control-bundle type and RUN-state rules.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_stall_ctrl_pkg;

  localparam int STALL_CNT_W = 32;

  // Fetch-control FSM state encoding (2 bits)
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_IMISS  = 2'd1,
    ST_REPLAY = 2'd2
  } fetch_state_e;

  // Front-end hazard controls driven to the pipeline registers and PC
  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_flush;
    logic redirect_replay;
  } fe_ctrl_t;

  // Priority-ordered hazard resolution used whenever the FSM is in RUN
  // (and on the cycle a miss ends with nothing pending).
  function automatic fe_ctrl_t run_rules(input logic dstall,
                                         input logic flush,
                                         input logic imiss,
                                         input logic load_use);
    fe_ctrl_t c;
    c = '0;
    if (dstall) begin
      c.pc_stall    = 1'b1;
      c.if_id_stall = 1'b1;
    end else if (flush) begin
      c.if_id_flush = 1'b1;
      c.id_ex_flush = 1'b1;
    end else if (imiss) begin
      c.pc_stall    = 1'b1;
      c.if_id_flush = 1'b1;
    end else if (load_use) begin
      c.pc_stall    = 1'b1;
      c.if_id_stall = 1'b1;
      c.id_ex_flush = 1'b1;
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_stall_ctrl_stall_counter.sv
`default_nettype none
// ============================================================================
// Module      : stall_counter
// Description : Saturating count of front-end stall cycles. Only built when
//               FETCH_STALL_CNT_EN is defined; otherwise the output is a
//               constant zero and no flops are present.
// Revision    : 1.0 - initial release
// ============================================================================
module stall_counter #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

`ifdef FETCH_STALL_CNT_EN
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Increment on each stalled cycle, sticking at all-ones
  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register, cleared by the asynchronous active-low reset
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
`else
  logic unused_ok;
  assign unused_ok = ^{Clk, Rst, inc_i};
  assign count_o   = '0;
`endif

endmodule
`default_nettype wire

// File: rtl/fetch_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stall_ctrl
// Description : Front-end stall/flush controller. Resolves data stalls,
//               branch redirects, I-cache misses and load-use hazards, and
//               replays a redirect that arrived while a miss was pending.
//               Optional stall-cycle counter enabled by FETCH_STALL_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stall_ctrl
  import fetch_stall_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Imiss,
  input  logic              DStall,
  input  logic              LoadUse,
  input  logic              FlushPipeandPC,
  input  logic [ADDR_W-1:0] JmpAddr,
  output logic              PCStall,
  output logic              IF_ID_Stall,
  output logic              IF_ID_Flush,
  output logic              ID_EX_Flush,
  output logic              RedirectReplay,
  output logic [ADDR_W-1:0] ReplayAddr,
  output logic [31:0]       StallCycles
);

  fetch_state_e      state_q, state_d;
  logic              pending_q, pending_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  fe_ctrl_t          ctrl;

  // Next-state, redirect capture and zero-latency control outputs
  always_comb begin
    ctrl      = '0;
    state_d   = state_q;
    pending_d = pending_q;
    addr_d    = addr_q;
    case (state_q)
      ST_RUN: begin
        ctrl = run_rules(DStall, FlushPipeandPC, Imiss, LoadUse);
        if (!DStall && !FlushPipeandPC && Imiss) begin
          state_d = ST_IMISS;
        end
      end
      ST_IMISS: begin
        if (DStall) begin
          // Whole front end frozen: no capture, no transition, stall beats flush
          ctrl.pc_stall    = 1'b1;
          ctrl.if_id_stall = 1'b1;
        end else begin
          if (FlushPipeandPC) begin
            // Latest redirect during the miss overwrites any earlier one
            addr_d           = JmpAddr;
            pending_d        = 1'b1;
            ctrl.id_ex_flush = 1'b1;
          end
          if (Imiss) begin
            ctrl.pc_stall    = 1'b1;
            ctrl.if_id_flush = 1'b1;
          end else if (pending_q || FlushPipeandPC) begin
            // Hold fetch for one more cycle; the PC is reloaded by the replay
            ctrl.pc_stall    = 1'b1;
            ctrl.if_id_flush = 1'b1;
            state_d          = ST_REPLAY;
          end else begin
            ctrl    = run_rules(1'b0, 1'b0, 1'b0, LoadUse);
            state_d = ST_RUN;
          end
        end
      end
      ST_REPLAY: begin
        ctrl.redirect_replay = 1'b1;
        if (DStall) begin
          ctrl.if_id_stall = 1'b1;
        end else begin
          ctrl.if_id_flush = 1'b1;
          pending_d        = 1'b0;
          state_d          = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // FSM state, pending flag and captured redirect target
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q   <= ST_RUN;
      pending_q <= 1'b0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      addr_q    <= addr_d;
    end
  end

  assign PCStall        = ctrl.pc_stall;
  assign IF_ID_Stall    = ctrl.if_id_stall;
  assign IF_ID_Flush    = ctrl.if_id_flush;
  assign ID_EX_Flush    = ctrl.id_ex_flush;
  assign RedirectReplay = ctrl.redirect_replay;
  assign ReplayAddr     = addr_q;

  stall_counter #(
    .WIDTH (STALL_CNT_W)
  ) u_stall_counter (
    .Clk     (Clk),
    .Rst     (Rst),
    .inc_i   (ctrl.pc_stall),
    .count_o (StallCycles)
  );

endmodule
`default_nettype wire

// File: tb/tb_fetch_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stall_ctrl
// Description : Directed self-checking bench for fetch_stall_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stall_ctrl;

  logic        Clk;
  logic        Rst;
  logic        Imiss, DStall, LoadUse, FlushPipeandPC;
  logic [31:0] JmpAddr;
  logic        PCStall, IF_ID_Stall, IF_ID_Flush, ID_EX_Flush, RedirectReplay;
  logic [31:0] ReplayAddr;
  logic [31:0] StallCycles;
  logic [4:0]  outs;

  int n_checks;
  int n_fail;

  // {PCStall, IF_ID_Stall, IF_ID_Flush, ID_EX_Flush, RedirectReplay}
  assign outs = {PCStall, IF_ID_Stall, IF_ID_Flush, ID_EX_Flush, RedirectReplay};

  fetch_stall_ctrl #(.ADDR_W(32)) dut (
    .Clk            (Clk),
    .Rst            (Rst),
    .Imiss          (Imiss),
    .DStall         (DStall),
    .LoadUse        (LoadUse),
    .FlushPipeandPC (FlushPipeandPC),
    .JmpAddr        (JmpAddr),
    .PCStall        (PCStall),
    .IF_ID_Stall    (IF_ID_Stall),
    .IF_ID_Flush    (IF_ID_Flush),
    .ID_EX_Flush    (ID_EX_Flush),
    .RedirectReplay (RedirectReplay),
    .ReplayAddr     (ReplayAddr),
    .StallCycles    (StallCycles)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Drive one cycle of inputs at the falling edge, settle before sampling
  task automatic cyc(input logic im, input logic ds, input logic lu,
                     input logic fl, input logic [31:0] addr);
    @(negedge Clk);
    Imiss          = im;
    DStall         = ds;
    LoadUse        = lu;
    FlushPipeandPC = fl;
    JmpAddr        = addr;
    #1;
  endtask

  task automatic test_reset;
    Rst = 1'b0;
    Imiss = 1'b0; DStall = 1'b0; LoadUse = 1'b0; FlushPipeandPC = 1'b0;
    JmpAddr = 32'h0;
    #2;
    n_checks++;
    if (outs !== 5'b00000) begin
      n_fail++; $display("FAIL reset_outs: got %b expected %b", outs, 5'b00000);
    end
    n_checks++;
    if (ReplayAddr !== 32'h0) begin
      n_fail++; $display("FAIL reset_addr: got %h expected %h", ReplayAddr, 32'h0);
    end
    n_checks++;
    if (StallCycles !== 32'h0) begin
      n_fail++; $display("FAIL reset_cnt: got %h expected %h", StallCycles, 32'h0);
    end
    @(negedge Clk);
    Rst = 1'b1;
  endtask

  task automatic test_run_priority;
    logic [3:0] vin [0:4];   // {Imiss, DStall, LoadUse, Flush}
    logic [4:0] vexp [0:4];
    vin  = '{4'b0000, 4'b1111, 4'b0010, 4'b0011, 4'b0001};
    vexp = '{5'b00000, 5'b11000, 5'b11010, 5'b00110, 5'b00110};
    for (int i = 0; i < 5; i++) begin
      cyc(vin[i][3], vin[i][2], vin[i][1], vin[i][0], 32'hDEAD_0000);
      n_checks++;
      if (outs !== vexp[i]) begin
        n_fail++; $display("FAIL run_priority[%0d]: got %b expected %b", i, outs, vexp[i]);
      end
    end
  endtask

  task automatic test_imiss_plain;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      n_checks++;
      if (outs !== 5'b10100) begin
        n_fail++; $display("FAIL imiss_plain[%0d]: got %b expected %b", i, outs, 5'b10100);
      end
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (outs !== 5'b00000) begin
      n_fail++; $display("FAIL imiss_end: got %b expected %b", outs, 5'b00000);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      n_checks++;
      if (outs !== 5'b00000) begin
        n_fail++; $display("FAIL imiss_no_replay[%0d]: got %b expected %b", i, outs, 5'b00000);
      end
    end
  endtask

  task automatic test_redirect_last_wins;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0040);
    n_checks++;
    if (outs !== 5'b10110) begin
      n_fail++; $display("FAIL redir_cap1: got %b expected %b", outs, 5'b10110);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0080);
    n_checks++;
    if (outs !== 5'b10110) begin
      n_fail++; $display("FAIL redir_cap2: got %b expected %b", outs, 5'b10110);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1234);
    n_checks++;
    if (ReplayAddr !== 32'h0000_0080) begin
      n_fail++; $display("FAIL redir_addr: got %h expected %h", ReplayAddr, 32'h0000_0080);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (RedirectReplay !== 1'b0) begin
      n_fail++; $display("FAIL redir_early: got %b expected %b", RedirectReplay, 1'b0);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (outs !== 5'b00101 || ReplayAddr !== 32'h0000_0080) begin
      n_fail++; $display("FAIL redir_replay: got %b/%h expected %b/%h",
                         outs, ReplayAddr, 5'b00101, 32'h0000_0080);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (outs !== 5'b00000) begin
      n_fail++; $display("FAIL redir_single: got %b expected %b", outs, 5'b00000);
    end
  endtask

  task automatic test_replay_dstall;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0100);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      n_checks++;
      if (RedirectReplay !== 1'b1 || IF_ID_Stall !== 1'b1 || IF_ID_Flush !== 1'b0) begin
        n_fail++; $display("FAIL replay_dstall[%0d]: got RR/stall/flush %b%b%b expected 110",
                           i, RedirectReplay, IF_ID_Stall, IF_ID_Flush);
      end
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (outs !== 5'b00101 || ReplayAddr !== 32'h0000_0100) begin
      n_fail++; $display("FAIL replay_release: got %b/%h expected %b/%h",
                         outs, ReplayAddr, 5'b00101, 32'h0000_0100);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (outs !== 5'b00000) begin
      n_fail++; $display("FAIL replay_done: got %b expected %b", outs, 5'b00000);
    end
  endtask

  task automatic test_reset_mid_miss;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0200);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (ReplayAddr !== 32'h0000_0200) begin
      n_fail++; $display("FAIL rstmiss_cap: got %h expected %h", ReplayAddr, 32'h0000_0200);
    end
    @(negedge Clk);
    Imiss = 1'b0;
    Rst   = 1'b0;
    #1;
    n_checks++;
    if (ReplayAddr !== 32'h0 || outs !== 5'b00000) begin
      n_fail++; $display("FAIL rstmiss_async: got %h/%b expected %h/%b",
                         ReplayAddr, outs, 32'h0, 5'b00000);
    end
    @(negedge Clk);
    Rst = 1'b1;
    // A redirect resolves to the RUN rules only if the FSM is back in RUN
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0300);
    n_checks++;
    if (outs !== 5'b00110) begin
      n_fail++; $display("FAIL rstmiss_run: got %b expected %b", outs, 5'b00110);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      n_checks++;
      if (RedirectReplay !== 1'b0) begin
        n_fail++; $display("FAIL rstmiss_noreplay[%0d]: got %b expected %b",
                           i, RedirectReplay, 1'b0);
      end
    end
  endtask

  task automatic test_imiss_dstall;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0400);
    n_checks++;
    if (outs !== 5'b11000) begin
      n_fail++; $display("FAIL imiss_dstall: got %b expected %b", outs, 5'b11000);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (outs !== 5'b00000 || ReplayAddr !== 32'h0) begin
      n_fail++; $display("FAIL imiss_dstall_nocap: got %b/%h expected %b/%h",
                         outs, ReplayAddr, 5'b00000, 32'h0);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (RedirectReplay !== 1'b0) begin
      n_fail++; $display("FAIL imiss_dstall_noreplay: got %b expected %b", RedirectReplay, 1'b0);
    end
  endtask

  task automatic test_counter;
`ifdef FETCH_STALL_CNT_EN
    @(negedge Clk);
    dut.u_stall_counter.count_q = 32'hFFFF_FFFE;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (StallCycles !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL cnt_sat: got %h expected %h", StallCycles, 32'hFFFF_FFFF);
    end
`else
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (StallCycles !== 32'h0) begin
      n_fail++; $display("FAIL cnt_tied: got %h expected %h", StallCycles, 32'h0);
    end
`endif
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset;
    test_run_priority;
    test_imiss_plain;
    test_redirect_last_wins;
    test_replay_dstall;
    test_reset_mid_miss;
    test_imiss_dstall;
    test_counter;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
